// File: rtl/mem_if_arbiter.sv
// Shares one downstream memory port among NR_MASTERS requesters and routes in-order responses back through an ID FIFO.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; fixed lowest-index priority otherwise.
module mem_if_arbiter #(
  parameter int NR_MASTERS      = 2,
  parameter int ADDRESS_SIZE    = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NR_MASTERS*ADDRESS_SIZE-1:0]   m_address_i,
  input  logic [NR_MASTERS*32-1:0]             m_data_wdata_i,
  input  logic [NR_MASTERS-1:0]                m_data_req_i,
  input  logic [NR_MASTERS-1:0]                m_data_we_i,
  input  logic [NR_MASTERS*4-1:0]              m_data_be_i,
  output logic [NR_MASTERS-1:0]                m_data_gnt_o,
  output logic [NR_MASTERS-1:0]                m_data_rvalid_o,
  output logic [31:0]                          m_data_rdata_o,
  output logic [ADDRESS_SIZE-1:0]              mem_address_o,
  output logic [31:0]                          mem_data_wdata_o,
  output logic                                 mem_data_req_o,
  output logic                                 mem_data_we_o,
  output logic [3:0]                           mem_data_be_o,
  input  logic                                 mem_data_gnt_i,
  input  logic                                 mem_data_rvalid_i,
  input  logic [31:0]                          mem_data_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);

  localparam int IDW = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t    state, state_next;
  logic [IDW-1:0] lock_idx;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] id_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           full, empty, req, push, pop, err;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] prio;
  int unsigned    rr_idx;
  logic           found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    rr_idx = 0;
    for (int unsigned i = 0; i < NR_MASTERS; i++) begin
      rr_idx = (32'(prio) + i) % NR_MASTERS;
      if (!found && m_data_req_i[rr_idx]) begin
        winner = IDW'(rr_idx);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio <= '0;
    end else if (push) begin
      prio <= (sel == IDW'(NR_MASTERS - 1)) ? '0 : sel + 1'b1;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int unsigned i = NR_MASTERS; i > 0; i--) begin
      if (m_data_req_i[i-1]) winner = IDW'(i - 1);
    end
  end
`endif

  assign sel   = (state == LOCKED) ? lock_idx : winner;
  assign full  = (count == CW'(MAX_OUTSTANDING));
  assign empty = (count == '0);
  // Reset gates the request so nothing is granted while state is being cleared.
  assign req   = m_data_req_i[sel] & ~full & ~rst_i;
  assign push  = req & mem_data_gnt_i;
  assign pop   = mem_data_rvalid_i & ~empty;

  assign mem_data_req_o   = req;
  assign mem_address_o    = m_address_i[sel*ADDRESS_SIZE +: ADDRESS_SIZE];
  assign mem_data_wdata_o = m_data_wdata_i[sel*32 +: 32];
  assign mem_data_we_o    = m_data_we_i[sel];
  assign mem_data_be_o    = m_data_be_i[sel*4 +: 4];
  assign m_data_rdata_o   = mem_data_rdata_i;
  assign outstanding_o    = count;
  assign err_o            = err;

  always_comb begin
    m_data_gnt_o      = '0;
    m_data_gnt_o[sel] = push;
  end

  always_comb begin
    m_data_rvalid_o = '0;
    if (pop) m_data_rvalid_o[id_fifo[rd_ptr]] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      UNLOCKED: if (req && !mem_data_gnt_i) state_next = LOCKED;
      LOCKED:   if (push || !m_data_req_i[lock_idx]) state_next = UNLOCKED;
      default:  state_next = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= UNLOCKED;
      lock_idx <= '0;
    end else begin
      state <= state_next;
      if (state == UNLOCKED && req && !mem_data_gnt_i) lock_idx <= sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (push) begin
        id_fifo[wr_ptr] <= sel;
        wr_ptr          <= wrap_inc(wr_ptr);
      end
      if (pop) rd_ptr <= wrap_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (mem_data_rvalid_i && empty) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_if_arbiter.sv
// Directed bench for mem_if_arbiter: reset, contention, lock, full, back-to-back push/pop and spurious response.
module tb_mem_if_arbiter;

  localparam int NM = 2;
  localparam int AS = 64;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM*AS-1:0]  m_address;
  logic [NM*32-1:0]  m_wdata;
  logic [NM-1:0]     m_req, m_we;
  logic [NM*4-1:0]   m_be;
  logic [NM-1:0]     m_gnt, m_rvalid;
  logic [31:0]       m_rdata;
  logic [AS-1:0]     mem_address;
  logic [31:0]       mem_wdata;
  logic              mem_req, mem_we;
  logic [3:0]        mem_be;
  logic              mem_gnt, mem_rvalid;
  logic [31:0]       mem_rdata;
  logic [2:0]        outstanding;
  logic              err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_if_arbiter #(.NR_MASTERS(NM), .ADDRESS_SIZE(AS), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_address_i(m_address), .m_data_wdata_i(m_wdata), .m_data_req_i(m_req),
    .m_data_we_i(m_we), .m_data_be_i(m_be),
    .m_data_gnt_o(m_gnt), .m_data_rvalid_o(m_rvalid), .m_data_rdata_o(m_rdata),
    .mem_address_o(mem_address), .mem_data_wdata_o(mem_wdata), .mem_data_req_o(mem_req),
    .mem_data_we_o(mem_we), .mem_data_be_o(mem_be),
    .mem_data_gnt_i(mem_gnt), .mem_data_rvalid_i(mem_rvalid), .mem_data_rdata_i(mem_rdata),
    .outstanding_o(outstanding), .err_o(err)
  );

  // Inputs change 1 ns after posedge; checks run mid-cycle (posedge + 5 ns).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    cyc(); rst = 1'b1; idle();
    cyc();
    cyc(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_req = 2'b11; mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int c = 0; c < 2; c++) begin
      cyc(); #4;
      checks++; if (m_gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt c%0d got=%b exp=00", c, m_gnt); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req c%0d got=%b exp=0", c, mem_req); end
      checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL reset_outstanding c%0d got=%0d exp=0", c, outstanding); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err c%0d got=%b exp=0", c, err); end
    end
    cyc(); rst = 1'b0; idle(); #4;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL post_reset_req got=%b exp=0", mem_req); end
  endtask

  task automatic test_contention();
    int exp_id [8];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_id = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_id = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(); m_req = 2'b11; mem_gnt = 1'b1; mem_rvalid = (k >= 2); mem_rdata = 32'hA000 + k; #4;
      checks++; if (m_gnt !== (2'b01 << exp_id[k])) begin failures++; $display("FAIL cont_gnt k%0d got=%b exp_id=%0d", k, m_gnt, exp_id[k]); end
      checks++; if (mem_address !== (exp_id[k] == 1 ? 64'h200 : 64'h100)) begin failures++; $display("FAIL cont_addr k%0d got=%h", k, mem_address); end
      checks++; if (mem_wdata !== (exp_id[k] == 1 ? 32'h22222222 : 32'h11111111)) begin failures++; $display("FAIL cont_wdata k%0d got=%h", k, mem_wdata); end
      if (k >= 2) begin
        checks++; if (m_rvalid !== (2'b01 << exp_id[k-2])) begin failures++; $display("FAIL cont_rvalid k%0d got=%b exp_id=%0d", k, m_rvalid, exp_id[k-2]); end
        checks++; if (m_rdata !== 32'hA000 + k) begin failures++; $display("FAIL cont_rdata k%0d got=%h exp=%h", k, m_rdata, 32'hA000 + k); end
      end
    end
    for (int k = 6; k < 8; k++) begin
      cyc(); idle(); mem_rvalid = 1'b1; #4;
      checks++; if (m_rvalid !== (2'b01 << exp_id[k])) begin failures++; $display("FAIL cont_drain k%0d got=%b exp_id=%0d", k, m_rvalid, exp_id[k]); end
    end
    cyc(); idle(); #4;
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL cont_empty got=%0d exp=0", outstanding); end
  endtask

  task automatic test_lock();
    do_reset();
    m_address[AS +: AS] = 64'h80;
    for (int c = 0; c < 3; c++) begin
      cyc(); m_req = (c == 0) ? 2'b10 : 2'b11; mem_gnt = 1'b0; #4;
      checks++; if (mem_address !== 64'h80) begin failures++; $display("FAIL lock_addr c%0d got=%h exp=80", c, mem_address); end
      checks++; if (m_gnt !== 2'b00 || mem_req !== 1'b1) begin failures++; $display("FAIL lock_wait c%0d gnt=%b req=%b exp gnt=00 req=1", c, m_gnt, mem_req); end
    end
    cyc(); m_req = 2'b11; mem_gnt = 1'b1; #4;
    checks++; if (m_gnt !== 2'b10 || mem_address !== 64'h80) begin failures++; $display("FAIL lock_grant gnt=%b addr=%h exp 10/80", m_gnt, mem_address); end
    cyc(); m_req = 2'b01; mem_gnt = 1'b1; #4;
    checks++; if (m_gnt !== 2'b01 || mem_address !== 64'h100) begin failures++; $display("FAIL lock_next gnt=%b addr=%h exp 01/100", m_gnt, mem_address); end
    checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL lock_occ got=%0d exp=1", outstanding); end
    cyc(); idle(); mem_rvalid = 1'b1; #4;
    checks++; if (m_rvalid !== 2'b10) begin failures++; $display("FAIL lock_resp1 got=%b exp=10", m_rvalid); end
    cyc(); idle(); mem_rvalid = 1'b1; #4;
    checks++; if (m_rvalid !== 2'b01) begin failures++; $display("FAIL lock_resp2 got=%b exp=01", m_rvalid); end
    m_address[AS +: AS] = 64'h200;
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(); m_req = 2'b01; mem_gnt = 1'b1; #4;
      checks++; if (m_gnt !== 2'b01 || outstanding !== 3'(k)) begin failures++; $display("FAIL full_fill k%0d gnt=%b occ=%0d exp 01/%0d", k, m_gnt, outstanding, k); end
    end
    cyc(); #4;
    checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL full_occ got=%0d exp=4", outstanding); end
    checks++; if (mem_req !== 1'b0 || m_gnt !== 2'b00) begin failures++; $display("FAIL full_mask req=%b gnt=%b exp 0/00", mem_req, m_gnt); end
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hF00D; #4;
    checks++; if (m_rvalid !== 2'b01 || mem_req !== 1'b0) begin failures++; $display("FAIL full_pop rvalid=%b req=%b exp 01/0", m_rvalid, mem_req); end
    cyc(); mem_rvalid = 1'b0; #4;
    checks++; if (outstanding !== 3'd3 || mem_req !== 1'b1 || m_gnt !== 2'b01) begin failures++; $display("FAIL full_reassert occ=%0d req=%b gnt=%b exp 3/1/01", outstanding, mem_req, m_gnt); end
    for (int k = 0; k < 4; k++) begin
      cyc(); idle(); mem_rvalid = 1'b1; #4;
      checks++; if (m_rvalid !== 2'b01) begin failures++; $display("FAIL full_drain k%0d got=%b exp=01", k, m_rvalid); end
    end
    cyc(); idle(); #4;
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL full_empty got=%0d exp=0", outstanding); end
  endtask

  task automatic test_back_to_back();
    int ids [14] = '{1, 0, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1};
    do_reset();
    for (int k = 0; k < 14; k++) begin
      cyc(); m_req = 2'b01 << ids[k]; mem_gnt = 1'b1; mem_rvalid = (k >= 2); #4;
      checks++; if (m_gnt !== (2'b01 << ids[k])) begin failures++; $display("FAIL b2b_gnt k%0d got=%b exp_id=%0d", k, m_gnt, ids[k]); end
      checks++; if (outstanding !== 3'((k < 2) ? k : 2)) begin failures++; $display("FAIL b2b_occ k%0d got=%0d exp=%0d", k, outstanding, (k < 2) ? k : 2); end
      if (k >= 2) begin
        checks++; if (m_rvalid !== (2'b01 << ids[k-2])) begin failures++; $display("FAIL b2b_rvalid k%0d got=%b exp_id=%0d", k, m_rvalid, ids[k-2]); end
      end
    end
    for (int k = 12; k < 14; k++) begin
      cyc(); idle(); mem_rvalid = 1'b1; #4;
      checks++; if (m_rvalid !== (2'b01 << ids[k])) begin failures++; $display("FAIL b2b_drain k%0d got=%b exp_id=%0d", k, m_rvalid, ids[k]); end
    end
    cyc(); idle(); #4;
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL b2b_empty got=%0d exp=0", outstanding); end
  endtask

  task automatic test_spurious();
    do_reset();
    cyc(); idle(); mem_rvalid = 1'b1; #4;
    checks++; if (m_rvalid !== 2'b00 || err !== 1'b0) begin failures++; $display("FAIL spur_ignore rvalid=%b err=%b exp 00/0", m_rvalid, err); end
    for (int c = 0; c < 3; c++) begin
      cyc(); idle(); #4;
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL spur_err_sticky c%0d got=%b exp=1", c, err); end
    end
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL spur_occ got=%0d exp=0", outstanding); end
    do_reset();
    cyc(); #4;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL spur_err_clear got=%b exp=0", err); end
  endtask

  initial begin
    m_address = '0;
    m_address[0 +: AS]  = 64'h100;
    m_address[AS +: AS] = 64'h200;
    m_wdata = {32'h22222222, 32'h11111111};
    m_we    = 2'b10;
    m_be    = {4'h3, 4'hF};
    test_reset();
    test_contention();
    test_lock();
    test_full();
    test_back_to_back();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
